// File: rtl/rr_arb_tree_pipe_ic.sv
// Rotating round-robin N-to-1 arbiter for the icache interconnect, with burst hold
// and an optional 2-entry output buffer toward the cache bank.
module rr_arb_tree_pipe_ic #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 20,
  parameter int N_MASTER   = 16,
  parameter int MAX_BURST  = 4,
  parameter int OUT_REG    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTER-1:0]            data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i,
  output logic [N_MASTER-1:0]            data_gnt_o,
  output logic                           data_req_o,
  output logic [ADDR_WIDTH-1:0]          data_add_o,
  output logic [ID_WIDTH-1:0]            data_ID_o,
  input  logic                           data_gnt_i
);

  localparam int PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int RUN_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam int ENT_W = ADDR_WIDTH + ID_WIDTH;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      last_w;
  logic [RUN_W-1:0]      run;
  logic [RUN_W-1:0]      run_n;
  logic [PTR_W-1:0]      win;
  logic [PTR_W:0]        idx;
  logic                  found;
  logic                  any_req;
  logic                  accept;
  logic                  buf_full;
  logic [ADDR_WIDTH-1:0] sel_add;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [ENT_W-1:0]      sel_ent;

  assign any_req = |data_req_i;

  // Search ptr, ptr+1, ... wrapping at N_MASTER (works for non-power-of-two N).
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N_MASTER)) idx = idx - (PTR_W+1)'(N_MASTER);
      if (!found && data_req_i[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_add = '0;
    sel_id  = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (any_req && win == PTR_W'(i)) begin
        sel_add = data_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_id  = data_ID_i[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  assign sel_ent = {sel_add, sel_id};

  always_comb begin
    if (OUT_REG != 0) accept = any_req && !buf_full && !rst;
    else              accept = any_req && data_gnt_i && !rst;
  end

  always_comb begin
    data_gnt_o = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      data_gnt_o[i] = accept && (win == PTR_W'(i));
    end
  end

  assign run_n = (win == last_w) ? run + 1'b1 : RUN_W'(1);

  // Burst hold: priority stays on the winner until it has MAX_BURST grants in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      last_w <= '0;
      run    <= '0;
    end else if (accept) begin
      last_w <= win;
      if (run_n == RUN_W'(MAX_BURST)) begin
        ptr <= (win == PTR_W'(N_MASTER-1)) ? '0 : win + 1'b1;
        run <= '0;
      end else begin
        ptr <= win;
        run <= run_n;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_buf
      logic [1:0]       cnt;
      logic [ENT_W-1:0] ent0;
      logic [ENT_W-1:0] ent1;
      logic             push;
      logic             pop;

      assign push = accept;
      assign pop  = (cnt != 2'd0) && data_gnt_i;

      // ent0 is always the head; push+pop together only happens at cnt==1.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt  <= '0;
          ent0 <= '0;
          ent1 <= '0;
        end else begin
          case ({push, pop})
            2'b11: ent0 <= sel_ent;
            2'b10: begin
              if (cnt == 2'd0) ent0 <= sel_ent;
              else             ent1 <= sel_ent;
              cnt <= cnt + 2'd1;
            end
            2'b01: begin
              ent0 <= ent1;
              cnt  <= cnt - 2'd1;
            end
            default: ;
          endcase
        end
      end

      assign buf_full               = (cnt == 2'd2);
      assign data_req_o             = (cnt != 2'd0);
      assign {data_add_o, data_ID_o} = ent0;
    end else begin : g_comb
      assign buf_full   = 1'b0;
      assign data_req_o = any_req;
      assign data_add_o = sel_add;
      assign data_ID_o  = sel_id;
    end
  endgenerate

endmodule
